// File: rtl/mem_frame_streamer.sv
// Streams one length-prefixed frame from single-port SRAM onto a valid/ready byte stream.
// Build option: define MEM_STREAM_HDR_EMIT_EN to emit the adjusted header as the first beat.
module mem_frame_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned HDR_ADJ    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1) + 2;
  localparam int unsigned EW = DATA_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR_REQ, S_HDR_WAIT, S_STREAM, S_FIN} state_t;
  state_t state_q, state_d;

  logic                  busy_q, busy_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_v_q, out_v_d, out_last_q, out_last_d;
  logic                  csb_q, csb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] len_q, len_d, issued_q, issued_d;
  logic                  p1_q, p1_d, p1_last_q, p1_last_d;
  logic                  p2_q, p2_d, p2_last_q, p2_last_d;
  logic [EW-1:0]         fifo_q [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic                  start_ok, xfer, push, pop, hdr_load;
  logic [EW-1:0]         push_entry;
  logic [CW-1:0]         occ;

  assign start_ok = i_start & ~busy_q & (state_q == S_IDLE);
  assign xfer     = out_v_q & i_ready;
  // p1: read on the bus this cycle; p2: its data is on dout0 and lands at the next edge
  assign occ      = CW'(out_v_q) + CW'(cnt_q) + CW'(p1_q) + CW'(p2_q) - CW'(xfer);

`ifdef MEM_STREAM_HDR_EMIT_EN
  logic [DATA_WIDTH-1:0] hdr_val;
  assign hdr_val    = (dout0 > DATA_WIDTH'(HDR_ADJ)) ? dout0 - DATA_WIDTH'(HDR_ADJ) : '0;
  assign hdr_load   = (state_q == S_HDR_WAIT);
  assign push_entry = hdr_load ? {dout0 == '0, hdr_val} : {p2_last_q, dout0};
`else
  logic [31:0] unused_hdr_adj;
  assign unused_hdr_adj = HDR_ADJ;
  assign hdr_load       = 1'b0;
  assign push_entry     = {p2_last_q, dout0};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_ok) state_d = S_HDR_REQ;
      S_HDR_REQ:  state_d = S_HDR_WAIT;
      S_HDR_WAIT: state_d = (dout0 == '0 && !hdr_load) ? S_FIN : S_STREAM;
      S_STREAM:   if (xfer && out_last_q) state_d = S_FIN;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    csb_d      = 1'b1;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    p1_d       = 1'b0;
    p1_last_d  = 1'b0;
    p2_d       = p1_q;
    p2_last_d  = p1_last_q;
    out_data_d = out_data_q;
    out_v_d    = out_v_q;
    out_last_d = out_last_q;
    push       = 1'b0;
    pop        = 1'b0;
    done_d     = (state_q == S_FIN);
    busy_d     = (state_d != S_IDLE) || done_d;

    case (state_q)
      S_IDLE: if (start_ok) begin
        csb_d  = 1'b0;
        addr_d = i_base_addr;
      end
      S_HDR_WAIT: begin
        len_d    = dout0;
        issued_d = '0;
        if (dout0 != '0) begin
          csb_d     = 1'b0;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          issued_d  = DATA_WIDTH'(1);
          p1_d      = 1'b1;
          p1_last_d = (dout0 == DATA_WIDTH'(1));
        end
      end
      S_STREAM: if (issued_q != len_q && occ <= CW'(BUF_DEPTH)) begin
        csb_d     = 1'b0;
        addr_d    = addr_q + ADDR_WIDTH'(1);
        issued_d  = issued_q + DATA_WIDTH'(1);
        p1_d      = 1'b1;
        p1_last_d = (issued_q + DATA_WIDTH'(1) == len_q);
      end
      default: ;
    endcase

    // Header is queued rather than presented directly so it appears one edge after capture
    if (hdr_load) begin
      push = 1'b1;
    end else if (!out_v_q || xfer) begin
      if (cnt_q != '0) begin
        {out_last_d, out_data_d} = fifo_q[rd_ptr_q];
        out_v_d = 1'b1;
        pop     = 1'b1;
        push    = p2_q;
      end else if (p2_q) begin
        {out_last_d, out_data_d} = {p2_last_q, dout0};
        out_v_d = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else begin
      push = p2_q;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
      csb_q      <= 1'b1;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      p1_q       <= 1'b0;
      p1_last_q  <= 1'b0;
      p2_q       <= 1'b0;
      p2_last_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_data_q <= out_data_d;
      out_v_q    <= out_v_d;
      out_last_q <= out_last_d;
      csb_q      <= csb_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      p1_q       <= p1_d;
      p1_last_q  <= p1_last_d;
      p2_q       <= p2_d;
      p2_last_q  <= p2_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_data  = out_data_q;
  assign o_valid = out_v_q;
  assign o_last  = out_last_q;
  assign csb0    = csb_q;
  assign web0    = 1'b1;
  assign addr0   = addr_q;

endmodule
